// File: rtl/vga_capture.sv
// vga_capture
//   Receive side of the VGA link. Samples an incoming active-low-sync RGB
//   stream, runs a replica of the transmitter's phase/h/line counters that is
//   realigned on every sync fall, qualifies lock over several frames and then
//   writes every visible pixel into the framebuffer.
//   The H/V timing parameters default to 640x480@60 and exist only so a
//   shortened raster can be used; production instances keep the defaults.
// Ports
//   i_Clock            system clock (single clock domain)
//   i_Reset_N          asynchronous active-low reset
//   i_RGB              incoming pixel data
//   i_Horizontal_Sync  active-low hsync
//   i_Vertical_Sync    active-low vsync
//   o_Fb_Write_Addr    framebuffer address, line*H_ACTIVE + h
//   o_Fb_Write_Data    sampled pixel
//   o_Fb_Write_Enable  one-cycle write strobe
//   o_Locked           high while the tracker is locked
//   o_Frame_Start      pulse together with the strobe for line 0, h 0
module vga_capture #(
  parameter int BITS_PER_PIXEL   = 3,
  parameter int CLOCKS_PER_PIXEL = 4,
  parameter int FRAMES_TO_LOCK   = 2,
  parameter int H_ACTIVE         = 640,
  parameter int H_FRONT          = 16,
  parameter int H_SYNC           = 96,
  parameter int H_BACK           = 48,
  parameter int V_ACTIVE         = 480,
  parameter int V_FRONT          = 10,
  parameter int V_SYNC           = 2,
  parameter int V_BACK           = 33
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset_N,
  input  logic [BITS_PER_PIXEL-1:0] i_RGB,
  input  logic                      i_Horizontal_Sync,
  input  logic                      i_Vertical_Sync,
  output logic [31:0]               o_Fb_Write_Addr,
  output logic [BITS_PER_PIXEL-1:0] o_Fb_Write_Data,
  output logic                      o_Fb_Write_Enable,
  output logic                      o_Locked,
  output logic                      o_Frame_Start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [15:0] H_LAST       = 16'(H_TOTAL - 1);
  localparam logic [15:0] H_SYNC_START = 16'(H_ACTIVE + H_FRONT);
  localparam logic [15:0] H_SYNC_PRE   = 16'(H_ACTIVE + H_FRONT - 1);
  localparam logic [15:0] H_VISIBLE    = 16'(H_ACTIVE);
  localparam logic [15:0] V_LAST       = 16'(V_TOTAL - 1);
  localparam logic [15:0] V_SYNC_START = 16'(V_ACTIVE + V_FRONT);
  localparam logic [15:0] V_SYNC_PRE   = 16'(V_ACTIVE + V_FRONT - 1);
  localparam logic [15:0] V_VISIBLE    = 16'(V_ACTIVE);
  localparam logic [7:0]  PHASE_LAST   = 8'(CLOCKS_PER_PIXEL - 1);
  localparam logic [7:0]  PHASE_SAMPLE = 8'(CLOCKS_PER_PIXEL / 2);
  localparam logic [7:0]  LOCK_COUNT   = 8'(FRAMES_TO_LOCK);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // [0] and [1] form the synchronizer, [2] is the previous value for edge detect
  logic [2:0]                hs_r;
  logic [2:0]                vs_r;
  logic [BITS_PER_PIXEL-1:0] rgb_s1_r;
  logic [BITS_PER_PIXEL-1:0] rgb_s2_r;

  logic [7:0]  phase_r;
  logic [15:0] h_r;
  logic [15:0] line_r;
  state_t      state_r;
  state_t      state_next_s;
  logic [7:0]  match_cnt_r;
  logic [7:0]  match_cnt_next_s;

  logic h_fall_s;
  logic v_fall_s;
  logic pix_end_s;
  logic line_end_s;
  logic h_expect_s;
  logic v_expect_s;
  logic sync_err_s;
  logic sample_s;

  // Synchronize the asynchronous video inputs; syncs idle high out of reset
  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      hs_r     <= 3'b111;
      vs_r     <= 3'b111;
      rgb_s1_r <= {BITS_PER_PIXEL{1'b1}};
      rgb_s2_r <= {BITS_PER_PIXEL{1'b1}};
    end else begin
      hs_r     <= {hs_r[1:0], i_Horizontal_Sync};
      vs_r     <= {vs_r[1:0], i_Vertical_Sync};
      rgb_s1_r <= i_RGB;
      rgb_s2_r <= rgb_s1_r;
    end
  end

  // Edge detection and expected-edge positions of the replica counters.
  // A fall is matched exactly when it coincides with its expected cycle, so
  // any disagreement between "fall seen" and "fall expected" is a loss.
  always_comb begin
    h_fall_s   = hs_r[2] & ~hs_r[1];
    v_fall_s   = vs_r[2] & ~vs_r[1];
    pix_end_s  = (phase_r == PHASE_LAST);
    line_end_s = pix_end_s && (h_r == H_LAST);
    h_expect_s = pix_end_s && (h_r == H_SYNC_PRE);
    v_expect_s = line_end_s && (line_r == V_SYNC_PRE);
    sync_err_s = (h_fall_s != h_expect_s) || (v_fall_s != v_expect_s);
  end

  // Replica of the transmitter counters, realigned on sync falls in every state
  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      phase_r <= 8'd0;
      h_r     <= 16'd0;
      line_r  <= 16'd0;
    end else begin
      if (h_fall_s) begin
        phase_r <= 8'd0;
        h_r     <= H_SYNC_START;
      end else if (pix_end_s) begin
        phase_r <= 8'd0;
        h_r     <= (h_r == H_LAST) ? 16'd0 : h_r + 16'd1;
      end else begin
        phase_r <= phase_r + 8'd1;
      end
      // An hsync realignment replaces the h wrap, so it must not bump the line
      if (v_fall_s) begin
        line_r <= V_SYNC_START;
      end else if (line_end_s && !h_fall_s) begin
        line_r <= (line_r == V_LAST) ? 16'd0 : line_r + 16'd1;
      end
    end
  end

  // Lock qualification next-state logic
  always_comb begin
    state_next_s     = state_r;
    match_cnt_next_s = match_cnt_r;
    case (state_r)
      SEARCH: begin
        if (v_fall_s) begin
          state_next_s     = TRACK;
          match_cnt_next_s = 8'd0;
        end else begin
          state_next_s = SEARCH;
        end
      end
      TRACK: begin
        if (sync_err_s) begin
          state_next_s = SEARCH;
        end else if (v_fall_s) begin
          match_cnt_next_s = match_cnt_r + 8'd1;
          if (match_cnt_r + 8'd1 >= LOCK_COUNT) begin
            state_next_s = LOCKED;
          end else begin
            state_next_s = TRACK;
          end
        end else begin
          state_next_s = TRACK;
        end
      end
      LOCKED: begin
        if (sync_err_s) begin
          state_next_s = SEARCH;
        end else begin
          state_next_s = LOCKED;
        end
      end
      default: begin
        state_next_s     = SEARCH;
        match_cnt_next_s = 8'd0;
      end
    endcase
  end

  // Lock qualification state register
  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      state_r     <= SEARCH;
      match_cnt_r <= 8'd0;
    end else begin
      state_r     <= state_next_s;
      match_cnt_r <= match_cnt_next_s;
    end
  end

  // Mid-pixel sample point of a visible pixel; a cycle that loses lock never writes
  always_comb begin
    sample_s = (state_r == LOCKED) && !sync_err_s && (phase_r == PHASE_SAMPLE) &&
               (h_r < H_VISIBLE) && (line_r < V_VISIBLE);
  end

  // Registered framebuffer write port and status outputs
  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      o_Fb_Write_Addr   <= 32'd0;
      o_Fb_Write_Data   <= {BITS_PER_PIXEL{1'b0}};
      o_Fb_Write_Enable <= 1'b0;
      o_Locked          <= 1'b0;
      o_Frame_Start     <= 1'b0;
    end else begin
      o_Fb_Write_Enable <= sample_s;
      o_Frame_Start     <= sample_s && (h_r == 16'd0) && (line_r == 16'd0);
      o_Locked          <= (state_next_s == LOCKED);
      if (sample_s) begin
        o_Fb_Write_Addr <= 32'(line_r) * 32'(H_ACTIVE) + 32'(h_r);
        o_Fb_Write_Data <= rgb_s2_r;
      end
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture
//   Bench for vga_capture on a shortened raster (8x6 visible, 16x11 total).
//   A transmitter model drives the active DUT; every visible pixel it emits
//   while the bench expects lock is pushed to a scoreboard and popped when the
//   DUT strobes. The transmitter's pixel data lags its syncs by one clock, as
//   with a registered framebuffer read. dut_a runs 4 clocks/pixel, dut_b 2.
module tb_vga_capture;

  localparam int HA  = 8;
  localparam int HF  = 2;
  localparam int HSW = 3;
  localparam int HB  = 3;
  localparam int HT  = HA + HF + HSW + HB;
  localparam int VA  = 6;
  localparam int VF  = 1;
  localparam int VSW = 2;
  localparam int VB  = 2;
  localparam int VT  = VA + VF + VSW + VB;

  localparam int K_IDLE   = 0;
  localparam int K_CLEAN  = 1;
  localparam int K_HDELAY = 2;
  localparam int K_VSUP   = 3;
  localparam int K_RESET  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [2:0]  rgb_a = 3'd0, rgb_b = 3'd0;
  logic        hs_a = 1'b1, vs_a = 1'b1, hs_b = 1'b1, vs_b = 1'b1;
  logic [31:0] addr_a, addr_b;
  logic [2:0]  data_a, data_b;
  logic        we_a, we_b, lk_a, lk_b, fs_a, fs_b;

  always #5 clk = ~clk;

  vga_capture #(
    .BITS_PER_PIXEL(3), .CLOCKS_PER_PIXEL(4), .FRAMES_TO_LOCK(2),
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB)
  ) dut_a (
    .i_Clock(clk), .i_Reset_N(rst_n), .i_RGB(rgb_a),
    .i_Horizontal_Sync(hs_a), .i_Vertical_Sync(vs_a),
    .o_Fb_Write_Addr(addr_a), .o_Fb_Write_Data(data_a),
    .o_Fb_Write_Enable(we_a), .o_Locked(lk_a), .o_Frame_Start(fs_a)
  );

  vga_capture #(
    .BITS_PER_PIXEL(3), .CLOCKS_PER_PIXEL(2), .FRAMES_TO_LOCK(2),
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB)
  ) dut_b (
    .i_Clock(clk), .i_Reset_N(rst_n), .i_RGB(rgb_b),
    .i_Horizontal_Sync(hs_b), .i_Vertical_Sync(vs_b),
    .o_Fb_Write_Addr(addr_b), .o_Fb_Write_Data(data_b),
    .o_Fb_Write_Enable(we_b), .o_Locked(lk_b), .o_Frame_Start(fs_b)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  data;
  } wr_t;

  typedef struct {
    int   act;
    int   kind;
    int   frames;
    int   writes;
    logic locked;
  } row_t;

  int   checks = 0;
  int   errors = 0;
  int   tick = 0;
  int   act = 0;
  int   ph = 0, h = 0, ln = 0;
  logic [2:0] prev_col = 3'd0;
  logic vs_out_prev = 1'b1;
  int   vfalls = 0;
  logic exp_locked = 1'b0;
  int   lock_tick = -100000;
  int   fault_tick = -100000;
  int   fault_h_line = -1;
  logic fault_v = 1'b0;
  logic lk_prev = 1'b0;
  int   writes = 0;
  wr_t  sb[$];
  row_t rows[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (tick %0d)", name, got, exp, tick);
    end
  endtask

  function automatic int cpp_of(input int d);
    return (d == 0) ? 4 : 2;
  endfunction

  // Compare what the DUTs show after the latest clock edge
  task automatic monitor();
    logic we, lk, fs, we_o, lk_o;
    logic [31:0] ad;
    logic [2:0] dt;
    wr_t e;
    if (act == 0) begin
      we = we_a; lk = lk_a; fs = fs_a; ad = addr_a; dt = data_a; we_o = we_b; lk_o = lk_b;
    end else begin
      we = we_b; lk = lk_b; fs = fs_b; ad = addr_b; dt = data_b; we_o = we_a; lk_o = lk_a;
    end
    chk("idle_dut_quiet", {30'd0, we_o, lk_o}, 32'd0);
    if (we) begin
      writes++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data %0d, expected no write (tick %0d)", ad, dt, tick);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", ad, e.addr);
        chk("wr_data", {29'd0, dt}, {29'd0, e.data});
        chk("frame_start", {31'd0, fs}, {31'd0, (e.addr == 32'd0)});
        // sampled at mid-pixel, seen 4 clocks after the transmitter emitted it
        chk("strobe_phase", 32'(ph), 32'((cpp_of(act) / 2 + 4) % cpp_of(act)));
      end
    end else if (fs) begin
      chk("frame_start_alone", {31'd0, fs}, 32'd0);
    end
    if (lk && !lk_prev) chk("lock_latency", 32'(tick - lock_tick), 32'd3);
    if (!lk && lk_prev && rst_n) chk("unlock_latency", 32'(tick - fault_tick), 32'd3);
    lk_prev = lk;
  endtask

  // Transmitter model: drive syncs for the current position, data one clock late
  task automatic tx_drive();
    logic hs_m, vs_m;
    logic [2:0] col;
    wr_t e;
    hs_m = !((h >= HA + HF) && (h < HA + HF + HSW));
    vs_m = !((ln >= VA + VF) && (ln < VA + VF + VSW));
    if (ln == fault_h_line && h == HA + HF && ph == 0) begin
      hs_m = 1'b1;
      fault_h_line = -1;
      exp_locked = 1'b0;
      vfalls = 0;
      fault_tick = tick;
    end
    if (fault_v) begin
      if (!vs_m && ln == VA + VF && h == 0 && ph == 0) begin
        exp_locked = 1'b0;
        vfalls = 0;
        fault_tick = tick;
      end
      if (ln == VA + VF + VSW) fault_v = 1'b0;
      vs_m = 1'b1;
    end
    if (vs_out_prev && !vs_m) begin
      vfalls++;
      if (vfalls == 3) begin
        exp_locked = 1'b1;
        lock_tick = tick;
      end
    end
    col = (ln < VA && h < HA) ? 3'((ln * HA + h) % 8) : 3'd0;
    if (exp_locked && ln < VA && h < HA && ph == 0) begin
      e.addr = 32'(ln * HA + h);
      e.data = col;
      sb.push_back(e);
    end
    if (act == 0) begin
      rgb_a = prev_col; hs_a = hs_m; vs_a = vs_m;
      rgb_b = 3'd0;     hs_b = 1'b1; vs_b = 1'b1;
    end else begin
      rgb_b = prev_col; hs_b = hs_m; vs_b = vs_m;
      rgb_a = 3'd0;     hs_a = 1'b1; vs_a = 1'b1;
    end
    prev_col = col;
    vs_out_prev = vs_m;
    ph++;
    if (ph == cpp_of(act)) begin
      ph = 0;
      h++;
      if (h == HT) begin
        h = 0;
        ln++;
        if (ln == VT) ln = 0;
      end
    end
  endtask

  task automatic chk_zero_outputs(input string name);
    if (act == 0) chk(name, addr_a | {29'd0, data_a} | {29'd0, we_a, lk_a, fs_a}, 32'd0);
    else          chk(name, addr_b | {29'd0, data_b} | {29'd0, we_b, lk_b, fs_b}, 32'd0);
  endtask

  initial begin
    int total, reset_at;
    rows[0] = '{0, K_IDLE,   2,  0, 1'b0};
    rows[1] = '{0, K_CLEAN,  4, 48, 1'b1};
    rows[2] = '{0, K_CLEAN,  1, 48, 1'b1};
    rows[3] = '{0, K_HDELAY, 4, 72, 1'b1};
    rows[4] = '{0, K_VSUP,   4, 48, 1'b1};
    rows[5] = '{0, K_CLEAN,  1, 48, 1'b1};
    rows[6] = '{0, K_RESET,  4, 76, 1'b1};
    rows[7] = '{1, K_RESET,  4, 48, 1'b1};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset_state_a");
    chk("reset_state_b", addr_b | {29'd0, data_b} | {29'd0, we_b, lk_b, fs_b}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      writes = 0;
      total = rows[i].frames * VT * HT * cpp_of(rows[i].act);
      reset_at = (rows[i].act == 0) ? (3 * HT + 5) * cpp_of(0) : 0;
      if (rows[i].kind == K_HDELAY) fault_h_line = 2;
      if (rows[i].kind == K_VSUP) fault_v = 1'b1;
      for (int r = 0; r < total; r++) begin
        @(posedge clk);
        #1;
        tick++;
        monitor();
        if (rows[i].kind == K_IDLE) begin
          chk("search_no_lock", {31'd0, lk_a}, 32'd0);
          rgb_a = 3'($urandom_range(0, 7));
          hs_a = 1'b1;
          vs_a = 1'b1;
        end else begin
          if (rows[i].kind == K_RESET && r == reset_at) begin
            rst_n = 1'b0;
            #1;
            sb.delete();
            exp_locked = 1'b0;
            vfalls = 0;
            act = rows[i].act;
            chk_zero_outputs("reset_async_clear");
          end else if (rows[i].kind == K_RESET && r > reset_at && r <= reset_at + 5) begin
            chk_zero_outputs("reset_held_zero");
            if (r == reset_at + 5) rst_n = 1'b1;
          end
          tx_drive();
        end
      end
      chk("row_pending", 32'(sb.size()), 32'd0);
      chk("row_writes", 32'(writes), 32'(rows[i].writes));
      chk("row_locked", {31'd0, (act == 0) ? lk_a : lk_b}, {31'd0, rows[i].locked});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
